// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its writeback arbiter.
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int SRC_A    = 0;
    localparam int SRC_B    = 1;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: absorbs a write, drops writes to $0,
// and exposes its destination as a one-hot pending bit.
module wb_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int REG_W  = regfile_pkg::REG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [REG_W-1:0]      load_reg_i,
    input  logic [DATA_W-1:0]     load_data_i,
    input  logic                  free_i,
    output logic                  fill_o,
    output logic                  full_o,
    output logic [REG_W-1:0]      reg_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [2**REG_W-1:0]   onehot_o
);
    logic              full_q, full_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign fill_o = load_i && (load_reg_i != '0);

    // Reload wins over free so a granted slot can refill on the same edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        full_d = full_q;
        reg_d  = reg_q;
        data_d = data_q;
        if (free_i) full_d = 1'b0;
        if (fill_o) begin
            full_d = 1'b1;
            reg_d  = load_reg_i;
            data_d = load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses <= so both slots and the arbiter see pre-edge values.
        if (!rst_n) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        onehot_o = '0;
        if (full_q) onehot_o[reg_q] = 1'b1;
    end

    assign full_o = full_q;
    assign reg_o  = reg_q;
    assign data_o = data_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: two buffered writeback sources, round-robin
// grant, same-register ordering by age, $0 writes discarded.
module reg_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int REG_W  = regfile_pkg::REG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [REG_W-1:0]    a_reg,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [REG_W-1:0]    b_reg,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                hold,
    output logic                we,
    output logic [REG_W-1:0]    reg_w,
    output logic [DATA_W-1:0]   bus_w,
    output logic [2**REG_W-1:0] pending
);
    logic [1:0]              full, fill, grant;
    logic [REG_W-1:0]        slot_reg  [2];
    logic [DATA_W-1:0]       slot_data [2];
    logic [2**REG_W-1:0]     slot_hot  [2];
    logic                    rr_q, rr_d;
    logic                    a_older_q, a_older_d;

    wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slot_a (
        .clk(clk), .rst_n(rst_n),
        .load_i(a_valid && a_ready), .load_reg_i(a_reg), .load_data_i(a_data),
        .free_i(grant[SRC_A]), .fill_o(fill[SRC_A]), .full_o(full[SRC_A]),
        .reg_o(slot_reg[SRC_A]), .data_o(slot_data[SRC_A]), .onehot_o(slot_hot[SRC_A])
    );

    wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slot_b (
        .clk(clk), .rst_n(rst_n),
        .load_i(b_valid && b_ready), .load_reg_i(b_reg), .load_data_i(b_data),
        .free_i(grant[SRC_B]), .fill_o(fill[SRC_B]), .full_o(full[SRC_B]),
        .reg_o(slot_reg[SRC_B]), .data_o(slot_data[SRC_B]), .onehot_o(slot_hot[SRC_B])
    );

    // Same destination must drain oldest-first; otherwise rr shares the port.
    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            if (full[SRC_A] && full[SRC_B]) begin
                if (slot_reg[SRC_A] == slot_reg[SRC_B]) begin
                    grant[SRC_A] = a_older_q;
                    grant[SRC_B] = !a_older_q;
                end else begin
                    grant[SRC_A] = !rr_q;
                    grant[SRC_B] = rr_q;
                end
            end else begin
                grant = full;
            end
        end
    end

    assign a_ready = !full[SRC_A] || grant[SRC_A];
    assign b_ready = !full[SRC_B] || grant[SRC_B];

    always_comb begin
        rr_d = rr_q;
        if (grant[SRC_A])      rr_d = 1'b1;
        else if (grant[SRC_B]) rr_d = 1'b0;

        a_older_d = a_older_q;
        if (fill[SRC_A] && fill[SRC_B])
            a_older_d = 1'b1;
        else if (fill[SRC_A] && full[SRC_B] && !grant[SRC_B])
            a_older_d = 1'b0;
        else if (fill[SRC_B] && full[SRC_A] && !grant[SRC_A])
            a_older_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            a_older_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            a_older_q <= a_older_d;
        end
    end

    always_comb begin
        we    = |grant;
        reg_w = '0;
        bus_w = '0;
        if (grant[SRC_A]) begin
            reg_w = slot_reg[SRC_A];
            bus_w = slot_data[SRC_A];
        end else if (grant[SRC_B]) begin
            reg_w = slot_reg[SRC_B];
            bus_w = slot_data[SRC_B];
        end
    end

    assign pending = slot_hot[SRC_A] | slot_hot[SRC_B];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares every cycle the DUT asserts we.
module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
    logic [RW-1:0] a_reg = '0, b_reg = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, we;
    logic [RW-1:0] reg_w;
    logic [DW-1:0] bus_w;
    logic [31:0]   pending;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;

    reg_wb_arbiter #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .hold(hold), .we(we), .reg_w(reg_w), .bus_w(bus_w), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", {63'd0, we}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_reg", {59'd0, reg_w}, {59'd0, mon_e.r});
                check("wr_data", {32'd0, bus_w}, {32'd0, mon_e.d});
            end
        end else begin
            check("idle_addr_data", {27'd0, reg_w, bus_w}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ia, ib;
        bit fa, fb;

        // Reset state
        #12;
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_a_ready", {63'd0, a_ready}, 64'd1);
        check("rst_b_ready", {63'd0, b_ready}, 64'd1);
        #1 rst_n = 1'b1;
        step();

        // Single write from A
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        @(negedge clk); check("t1_a_ready", {63'd0, a_ready}, 64'd1);
        step();
        a_valid = 1'b0;
        @(negedge clk); check("t1_pending5", {32'd0, pending}, 64'h20);
        check("t1_we", {63'd0, we}, 64'd1);
        step();
        @(negedge clk); check("t1_pending_clear", {32'd0, pending}, 64'd0);
        step();

        // Same register from both sources under hold: age overrides rr (rr=1 now)
        hold = 1'b1;
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'd1;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'd2;
        @(negedge clk); check("t3_b_ready", {63'd0, b_ready}, 64'd1);
        check("t3_hold_no_we", {63'd0, we}, 64'd0);
        step();
        b_valid = 1'b0;
        @(negedge clk);
        check("t3_pending4", {32'd0, pending}, 64'h10);
        check("t3_hold_a_ready", {63'd0, a_ready}, 64'd0);
        check("t3_hold_b_ready", {63'd0, b_ready}, 64'd0);
        exp_q.push_back('{5'd4, 32'd1});
        exp_q.push_back('{5'd4, 32'd2});
        step();
        hold = 1'b0;
        step();
        step();
        @(negedge clk); check("t3_pending_clear", {32'd0, pending}, 64'd0);
        step();

        // Contention, different registers, rr=0: A then B, b_ready low one cycle
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h77;
        exp_q.push_back('{5'd3, 32'h33});
        exp_q.push_back('{5'd7, 32'h77});
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("t2_b_ready_low", {63'd0, b_ready}, 64'd0);
        check("t2_a_ready", {63'd0, a_ready}, 64'd1);
        check("t2_pending", {32'd0, pending}, 64'h88);
        step();
        @(negedge clk); check("t2_b_ready_back", {63'd0, b_ready}, 64'd1);
        step();
        @(negedge clk); check("t2_idle", {63'd0, we}, 64'd0);
        step();

        // Write to $0 is accepted and dropped
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFFFFFF;
        @(negedge clk); check("t4_a_ready", {63'd0, a_ready}, 64'd1);
        step();
        a_valid = 1'b0;
        @(negedge clk); check("t4_pending", {32'd0, pending}, 64'd0);
        check("t4_we", {63'd0, we}, 64'd0);
        step();
        step();

        // Streaming: 4 writes per source, strict alternation A0 B0 A1 B1 ...
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{RW'(8 + i), 32'hA0000000 + 32'(i)});
            exp_q.push_back('{RW'(16 + i), 32'hB0000000 + 32'(i)});
        end
        ia = 0; ib = 0;
        for (int c = 0; c < 10; c++) begin
            a_valid = (ia < 4); a_reg = RW'(8 + ia);  a_data = 32'hA0000000 + 32'(ia);
            b_valid = (ib < 4); b_reg = RW'(16 + ib); b_data = 32'hB0000000 + 32'(ib);
            @(negedge clk);
            if (c >= 1 && c <= 8) check("t5_we_every_cycle", {63'd0, we}, 64'd1);
            if (c == 1) check("t5_b_loses", {63'd0, b_ready}, 64'd0);
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            step();
            if (fa) ia++;
            if (fb) ib++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("t5_a_accepted", 64'(ia), 64'd4);
        check("t5_b_accepted", 64'(ib), 64'd4);

        // Reset mid-cycle with both slots full
        hold = 1'b1;
        a_valid = 1'b1; a_reg = 5'd9;  a_data = 32'h99;
        b_valid = 1'b1; b_reg = 5'd10; b_data = 32'h1010;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); check("t6_pending_full", {32'd0, pending}, 64'h600);
        step();
        #1 rst_n = 1'b0;
        #1;
        check("t6_we", {63'd0, we}, 64'd0);
        check("t6_pending", {32'd0, pending}, 64'd0);
        check("t6_addr_data", {27'd0, reg_w, bus_w}, 64'd0);
        check("t6_a_ready", {63'd0, a_ready}, 64'd1);
        check("t6_b_ready", {63'd0, b_ready}, 64'd1);
        hold = 1'b0;
        step();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
